// File: rtl/fetch_if_stage.sv
// Instruction fetch stage with IF/ID register, one-entry skid buffer and redirect/HALT handling.
// Define FETCH_PERF_EN to add saturating request/hit counters.
module fetch_if_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_rd,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        imem_done,
    output logic [15:0] nxtPcIfId,
    output logic [15:0] instrIfId,
    output logic        validInsIfId,
    output logic [15:0] fetch_pc,
    output logic        fetch_halted
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] icache_req_count,
    output logic [31:0] icache_hit_count
`endif
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HALTED
    } state_t;

    state_t      r_state;
    logic [15:0] r_pc;
    logic [15:0] r_addr;
    logic        r_drop;
    logic        r_skid_vld;
    logic [15:0] r_skid_ins;
    logic [15:0] r_skid_npc;
    logic [15:0] r_ins;
    logic [15:0] r_npc;
    logic        r_vld;

    logic        w_req_blk;
    logic        w_deliv;
    logic        w_halt;
    logic [15:0] w_pc2;

    // A full skid buffer under stall has nowhere to put another word.
    assign w_req_blk = r_skid_vld && stall;

    assign imem_rd   = !rst && ((r_state == S_WAIT) ||
                                ((r_state == S_REQ) && !w_req_blk));
    assign imem_addr = (r_state == S_WAIT) ? r_addr : r_pc;
    assign w_pc2     = imem_addr + 16'd2;
    assign w_deliv   = imem_rd && imem_done && !r_drop && !redirect;
    assign w_halt    = (imem_data[15:11] == 5'b00000);

    assign nxtPcIfId    = r_npc;
    assign instrIfId    = r_ins;
    assign validInsIfId = r_vld;
    assign fetch_pc     = r_pc;
    assign fetch_halted = (r_state == S_HALTED);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_PC;
            r_addr     <= RESET_PC;
            r_drop     <= 1'b0;
            r_skid_vld <= 1'b0;
            r_skid_ins <= NOP_INSTR;
            r_skid_npc <= 16'h0000;
            r_ins      <= NOP_INSTR;
            r_npc      <= 16'h0000;
            r_vld      <= 1'b0;
        end else if (redirect) begin
            r_ins      <= NOP_INSTR;
            r_vld      <= 1'b0;
            r_skid_vld <= 1'b0;
            r_pc       <= redirect_pc;
            // An in-flight request must still complete; its data is thrown away.
            if (r_state == S_WAIT && !imem_done) begin
                r_drop <= 1'b1;
            end else begin
                r_drop  <= 1'b0;
                r_state <= S_REQ;
            end
        end else begin
            if (!stall) begin
                if (r_skid_vld) begin
                    r_ins      <= r_skid_ins;
                    r_npc      <= r_skid_npc;
                    r_vld      <= 1'b1;
                    r_skid_vld <= w_deliv;
                end else if (w_deliv) begin
                    r_ins <= imem_data;
                    r_npc <= w_pc2;
                    r_vld <= 1'b1;
                end else begin
                    r_ins <= NOP_INSTR;
                    r_vld <= 1'b0;
                end
            end else if (w_deliv) begin
                r_skid_vld <= 1'b1;
            end
            if (w_deliv) begin
                r_skid_ins <= imem_data;
                r_skid_npc <= w_pc2;
            end
            unique case (r_state)
                S_REQ: begin
                    if (imem_rd) begin
                        if (imem_done) begin
                            r_pc <= w_pc2;
                            if (w_halt) r_state <= S_HALTED;
                        end else begin
                            r_state <= S_WAIT;
                            r_addr  <= r_pc;
                        end
                    end
                end
                S_WAIT: begin
                    if (imem_done) begin
                        r_drop <= 1'b0;
                        if (r_drop) begin
                            r_state <= S_REQ;
                        end else begin
                            r_pc    <= w_pc2;
                            r_state <= w_halt ? S_HALTED : S_REQ;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            icache_req_count <= 32'd0;
            icache_hit_count <= 32'd0;
        end else if (r_state == S_REQ && imem_rd) begin
            if (icache_req_count != 32'hFFFF_FFFF)
                icache_req_count <= icache_req_count + 32'd1;
            if (imem_done && icache_hit_count != 32'hFFFF_FFFF)
                icache_hit_count <= icache_hit_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_if_stage.sv
// Bench for fetch_if_stage: directed plan items plus randomized traffic vs a queue-based model.
module tb_fetch_if_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic [15:0] imem_data = 16'h0000;
    logic        imem_done = 1'b0;
    logic [15:0] nxtPcIfId;
    logic [15:0] instrIfId;
    logic        validInsIfId;
    logic [15:0] fetch_pc;
    logic        fetch_halted;

    always #5 clk = ~clk;

    fetch_if_stage #(
        .RESET_PC (16'h0000),
        .NOP_INSTR(16'h0800)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_rd     (imem_rd),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .imem_done   (imem_done),
        .nxtPcIfId   (nxtPcIfId),
        .instrIfId   (instrIfId),
        .validInsIfId(validInsIfId),
        .fetch_pc    (fetch_pc),
        .fetch_halted(fetch_halted)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // memory: word table, latency per new request (lat<0 means random 0..2)
    logic [15:0] mem [logic [15:0]];
    int          lat = 0;
    bit          halt_ok = 1'b0;
    bit          mb = 1'b0;
    logic [15:0] ma = 16'h0;
    int          mc = 0;

    // reference model
    typedef struct packed {
        logic [15:0] ins;
        logic [15:0] npc;
    } slot_t;
    bit          m_known = 1'b0;
    logic [15:0] m_pc, m_waddr;
    bit          m_wait, m_drop, m_halt;
    slot_t       m_skid[$];
    logic [15:0] m_ins, m_npc;
    bit          m_val;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] fetch_word(input logic [15:0] a);
        logic [4:0] op;
        if (!mem.exists(a)) begin
            op = halt_ok ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 31));
            mem[a] = {op, 11'($urandom)};
        end
        return mem[a];
    endfunction

    function automatic bit m_rd();
        if (rst || !m_known) return 1'b0;
        return m_wait || (!m_halt && !(m_skid.size() > 0 && stall));
    endfunction

    task automatic compare();
        bit er;
        er = m_rd();
        if (rst || m_known) chk("imem_rd", {15'd0, imem_rd}, {15'd0, er});
        if (!m_known) return;
        if (er) chk("imem_addr", imem_addr, m_wait ? m_waddr : m_pc);
        chk("validInsIfId", {15'd0, validInsIfId}, {15'd0, m_val});
        chk("instrIfId", instrIfId, m_ins);
        if (m_val) chk("nxtPcIfId", nxtPcIfId, m_npc);
        chk("fetch_pc", fetch_pc, m_pc);
        chk("fetch_halted", {15'd0, fetch_halted}, {15'd0, m_halt});
    endtask

    task automatic model_update(input logic d, input logic [15:0] dat);
        bit          rd, fresh, hlt;
        logic [15:0] a, a2;
        slot_t       nw;
        rd = m_rd();
        a  = m_wait ? m_waddr : m_pc;
        a2 = a + 16'd2;
        if (rst) begin
            m_known = 1'b1;
            m_pc = 16'h0000;
            m_waddr = 16'h0000;
            m_wait = 1'b0;
            m_drop = 1'b0;
            m_halt = 1'b0;
            m_skid.delete();
            m_ins = 16'h0800;
            m_npc = 16'h0000;
            m_val = 1'b0;
            return;
        end
        if (!m_known) return;
        fresh = rd && d && !m_drop && !redirect;
        hlt   = fresh && (dat[15:11] == 5'd0);
        nw    = '{ins: dat, npc: a2};
        if (redirect) begin
            m_ins = 16'h0800;
            m_val = 1'b0;
            m_skid.delete();
            m_pc = redirect_pc;
            m_halt = 1'b0;
            if (m_wait && !d) begin
                m_drop = 1'b1;
            end else begin
                m_wait = 1'b0;
                m_drop = 1'b0;
            end
            return;
        end
        if (!stall) begin
            if (m_skid.size() > 0) begin
                nw = m_skid.pop_front();
                m_ins = nw.ins;
                m_npc = nw.npc;
                m_val = 1'b1;
                if (fresh) m_skid.push_back('{ins: dat, npc: a2});
            end else if (fresh) begin
                m_ins = dat;
                m_npc = a2;
                m_val = 1'b1;
            end else begin
                m_ins = 16'h0800;
                m_val = 1'b0;
            end
        end else if (fresh) begin
            m_skid.push_back(nw);
        end
        if (m_wait) begin
            if (d) begin
                m_wait = 1'b0;
                if (m_drop) m_drop = 1'b0;
                else begin
                    m_pc = a2;
                    m_halt = hlt;
                end
            end
        end else if (!m_halt && rd) begin
            if (d) begin
                m_pc = a2;
                m_halt = hlt;
            end else begin
                m_wait = 1'b1;
                m_waddr = m_pc;
            end
        end
    endtask

    task automatic step(input bit r, input bit s, input bit rd, input logic [15:0] rp);
        @(negedge clk);
        rst = r;
        stall = s;
        redirect = rd;
        redirect_pc = rp;
        #1;
        compare();
        imem_done = 1'b0;
        imem_data = 16'($urandom);
        if (imem_rd === 1'b1) begin
            if (!mb || ma != imem_addr) begin
                mb = 1'b1;
                ma = imem_addr;
                mc = (lat < 0) ? int'($urandom_range(0, 2)) : lat;
            end
            if (mc == 0) begin
                imem_done = 1'b1;
                imem_data = fetch_word(imem_addr);
                mb = 1'b0;
            end else begin
                mc--;
            end
        end else begin
            mb = 1'b0;
        end
        model_update(imem_done, imem_data);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 16'h0);
        step(1, 0, 0, 16'h0);
    endtask

    initial begin
        mem[16'h0000] = 16'h4001;
        mem[16'h0002] = 16'h4102;
        mem[16'h0004] = 16'h4203;
        mem[16'hFFFE] = 16'h4ABC;

        // zero-wait stream
        lat = 0;
        do_reset();
        chk("rst_instr", instrIfId, 16'h0800);
        chk("rst_valid", {15'd0, validInsIfId}, 16'h0000);
        chk("rst_npc", nxtPcIfId, 16'h0000);
        chk("rst_pc", fetch_pc, 16'h0000);
        chk("rst_halted", {15'd0, fetch_halted}, 16'h0000);
        chk("rst_rd", {15'd0, imem_rd}, 16'h0000);
        step(0, 0, 0, 16'h0);
        step(0, 0, 0, 16'h0);
        chk("s1_instr", instrIfId, 16'h4001);
        chk("s1_npc", nxtPcIfId, 16'h0002);
        step(0, 0, 0, 16'h0);
        chk("s2_instr", instrIfId, 16'h4102);
        chk("s2_npc", nxtPcIfId, 16'h0004);
        step(0, 0, 0, 16'h0);
        chk("s3_instr", instrIfId, 16'h4203);
        chk("s3_npc", nxtPcIfId, 16'h0006);
        chk("s3_valid", {15'd0, validInsIfId}, 16'h0001);

        // two wait cycles on the first fetch
        do_reset();
        lat = 2;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 16'h0);
            chk("wait_addr", imem_addr, 16'h0000);
            chk("wait_rd", {15'd0, imem_rd}, 16'h0001);
            chk("wait_novalid", {15'd0, validInsIfId}, 16'h0000);
        end
        lat = 0;
        step(0, 0, 0, 16'h0);
        chk("wait_instr", instrIfId, 16'h4001);
        chk("wait_valid", {15'd0, validInsIfId}, 16'h0001);

        // stall with skid buffer
        do_reset();
        step(0, 1, 0, 16'h0);
        step(0, 1, 0, 16'h0);
        chk("skid_rd0", {15'd0, imem_rd}, 16'h0000);
        step(0, 1, 0, 16'h0);
        chk("skid_rd0b", {15'd0, imem_rd}, 16'h0000);
        chk("skid_hold", {15'd0, validInsIfId}, 16'h0000);
        step(0, 0, 0, 16'h0);
        chk("skid_reissue", imem_addr, 16'h0002);
        step(0, 0, 0, 16'h0);
        chk("skid_instr", instrIfId, 16'h4001);
        chk("skid_npc", nxtPcIfId, 16'h0002);
        chk("skid_norefetch", imem_addr, 16'h0004);
        step(0, 0, 0, 16'h0);
        chk("skid_next", instrIfId, 16'h4102);

        // redirect during WAIT at 0x0010
        do_reset();
        for (int i = 0; i < 8; i++) step(0, 0, 0, 16'h0);
        lat = 3;
        step(0, 0, 0, 16'h0);
        chk("rdw_addr", imem_addr, 16'h0010);
        step(0, 0, 1, 16'h0100);
        lat = 0;
        step(0, 0, 0, 16'h0);
        chk("rdw_hold", imem_addr, 16'h0010);
        chk("rdw_pc", fetch_pc, 16'h0100);
        chk("rdw_squash", {15'd0, validInsIfId}, 16'h0000);
        step(0, 0, 0, 16'h0);
        step(0, 0, 0, 16'h0);
        chk("rdw_newaddr", imem_addr, 16'h0100);
        chk("rdw_drop", {15'd0, validInsIfId}, 16'h0000);

        // HALT at 0x0004, then redirect to 0x0020
        mem[16'h0004] = 16'h0000;
        do_reset();
        for (int i = 0; i < 4; i++) step(0, 0, 0, 16'h0);
        chk("halt_flag", {15'd0, fetch_halted}, 16'h0001);
        chk("halt_rd", {15'd0, imem_rd}, 16'h0000);
        chk("halt_flows", instrIfId, 16'h0000);
        step(0, 0, 0, 16'h0);
        chk("halt_rd2", {15'd0, imem_rd}, 16'h0000);
        step(0, 0, 1, 16'h0020);
        step(0, 0, 0, 16'h0);
        chk("resume_flag", {15'd0, fetch_halted}, 16'h0000);
        chk("resume_addr", imem_addr, 16'h0020);
        chk("resume_rd", {15'd0, imem_rd}, 16'h0001);
        mem[16'h0004] = 16'h4203;

        // PC wrap
        do_reset();
        step(0, 0, 1, 16'hFFFE);
        step(0, 0, 0, 16'h0);
        chk("wrap_addr0", imem_addr, 16'hFFFE);
        step(0, 0, 0, 16'h0);
        chk("wrap_addr", imem_addr, 16'h0000);
        chk("wrap_npc", nxtPcIfId, 16'h0000);
        chk("wrap_instr", instrIfId, 16'h4ABC);

        // randomized traffic
        halt_ok = 1'b1;
        lat = -1;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 9) < 3,
                 $urandom_range(0, 19) == 0,
                 16'($urandom) & 16'hFFFE);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_if_stage.md
Name: fetch_if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage 16-bit processor.
- Owns the PC and drives the stallable instruction memory with a request/done handshake.
- Absorbs hazard stalls through a one-entry skid buffer, and handles branch/jump redirects and HALT.
- Its IF/ID outputs (nxtPcIfId, instrIfId, validInsIfId) feed decode and are probed by the pipeline bench.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
NOP_INSTR, 16'h0800, encoding placed in instrIfId when the slot is invalid (opcode 00001)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
stall  in  1  hazard unit: hold IF/ID and PC this cycle
redirect  in  1  taken branch/jump resolved downstream: squash and refetch
redirect_pc  in  16  target PC for redirect
imem_rd  out  1  instruction memory read request
imem_addr  out  16  instruction memory address
imem_data  in  16  instruction returned; valid when imem_done=1
imem_done  in  1  memory completes the current request this cycle
nxtPcIfId  out  16  PC+2 of the instruction in IF/ID
instrIfId  out  16  instruction in IF/ID
validInsIfId  out  1  IF/ID holds a real instruction
fetch_pc  out  16  current fetch PC (debug)
fetch_halted  out  1  HALT has been fetched; fetch is stopped

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values: pc=RESET_PC; state=REQ; IF/ID: instrIfId=NOP_INSTR, nxtPcIfId=0, validInsIfId=0; skid buffer empty; drop flag=0; imem_rd=0 during the reset cycle; fetch_halted=0.
- FSM states: REQ, WAIT, HALTED.
- REQ:
  - imem_rd=1, imem_addr=pc.
  - imem_done=1 ("hit", zero-wait) → instruction is delivered; pc<=pc+2 (16-bit wrap, so 0xFFFE→0x0000); stay in REQ.
  - imem_done=0 → go to WAIT.
- WAIT:
  - imem_rd held at 1 with imem_addr held stable until imem_done.
  - On imem_done: deliver, pc<=pc+2, go to REQ.
- Delivery:
  - stall=0 and skid buffer empty → IF/ID loads {instr, pc+2, valid=1}.
  - stall=1 → instruction and its PC+2 go into the skid buffer. While the skid buffer is full, no new request is issued (imem_rd=0, stay in REQ).
  - First cycle with stall=0 and skid full → IF/ID loads from skid, skid empties, and a new request issues the same cycle.
  - stall=1 with nothing delivered → IF/ID holds its value.
  - stall=0 with nothing delivered → IF/ID becomes invalid (NOP_INSTR, valid=0).
- Latency: one cycle from imem_done to visibility in IF/ID on a zero-wait hit.
- HALT:
  - When an instruction with [15:11]=5'b00000 is delivered (to IF/ID or skid), the FSM enters HALTED.
  - In HALTED: imem_rd=0 and fetch_halted=1; the halt instruction still flows through normally.
- Redirect (highest priority, overrides stall for IF/ID):
  - Next cycle: IF/ID invalid (NOP_INSTR, valid=0), skid cleared, pc<=redirect_pc, fetch_halted cleared, state=REQ.
  - If a request is outstanding in WAIT without done: set drop=1, stay in WAIT; the returned data is discarded on done, then request redirect_pc.
  - If imem_done coincides with redirect: the returned data is discarded.
  - Redirect from HALTED resumes fetch at redirect_pc.
- rst mid-WAIT abandons the request; imem_rd drops the same cycle.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, adds outputs icache_req_count[31:0] and icache_hit_count[31:0], both reset to 0.
  - Req count increments once per new request accepted into REQ.
  - Hit count increments when imem_done=1 in REQ on the request's first cycle.
  - Both saturate at 0xFFFFFFFF.
  - Dropped (redirected) requests count as reqs, not hits.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then zero-wait memory returning 0x4001,0x4102,0x4203 → IF/ID shows those instructions with nxtPcIfId 0x0002,0x0004,0x0006 on consecutive cycles, valid=1.
- Memory with 2 wait cycles on the first fetch → imem_addr=0x0000 held for 3 cycles; instrIfId valid exactly one cycle after done.
- stall=1 for 3 cycles while 0x4001 returns → IF/ID holds the prior instruction; imem_rd=0 while skid is full; 0x4001 appears in IF/ID the cycle after stall drops, with no refetch of address 0x0002.
- Redirect to 0x0100 during WAIT at PC 0x0010 → returned data discarded; next imem_addr=0x0100; validInsIfId=0 for the squashed slot.
- Fetch 0x0000 (HALT) at PC 0x0004 → fetch_halted=1, imem_rd=0 thereafter; then redirect to 0x0020 → fetch resumes at 0x0020, fetch_halted=0.
- PC at 0xFFFE with zero-wait memory → next imem_addr=0x0000; nxtPcIfId=0x0000.
